rr_arb_mux: RTL and testbench

Parametrised arbitrating multiplexer that is the registered, flow-controlled successor of the team's combinational parameterised mux. 2**NUM_SLCT_LNS requesting channels, each with a valid/ready handshake, compete for one output. A round-robin arbiter picks one channel per cycle. The winning packet is loaded into a single output register, which holds it until the downstream consumer accepts it. The block sits between multiple packet producers and a single shared sink.

---
 rtl/rr_arb_mux.sv | 90 +++++++++
 tb/tb_rr_arb_mux.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered, flow-controlled arbitrating mux.
// 2**NUM_SLCT_LNS valid/ready channels compete for a single output register.
// A round-robin arbiter picks one winner per cycle.
// Define RR_ARB_MUX_FIXED_PRIO_EN to switch the arbiter to fixed priority,
// where the lowest-indexed valid channel wins.
module rr_arb_mux #(
    parameter int NUM_SLCT_LNS = 2,
    parameter int PCK_SZ       = 4,
    localparam int N           = 1 << NUM_SLCT_LNS
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N-1:0]            i_valid,
    input  logic [PCK_SZ-1:0]       i_input_signal [N-1:0],
    output logic [N-1:0]            o_ready,
    output logic                    o_valid,
    output logic [PCK_SZ-1:0]       o_out,
    output logic [NUM_SLCT_LNS-1:0] o_grant,
    input  logic                    i_ready
);

    logic                    load_ok;
    logic                    any_valid;
    logic                    xfer;
    logic [NUM_SLCT_LNS-1:0] winner;

    assign load_ok   = !o_valid || i_ready;
    assign any_valid = |i_valid;
    assign xfer      = |(i_valid & o_ready);

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    // Fixed priority: scan from the top down so the lowest valid index wins.
    always_comb begin
        winner = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_valid[i]) winner = NUM_SLCT_LNS'(i);
        end
    end
`else
    logic [NUM_SLCT_LNS-1:0] last;
    logic [NUM_SLCT_LNS-1:0] idx;
    logic                    found;

    // Round-robin: first valid channel after `last`, wrapping modulo N.
    // The offset i == N truncates to zero, so `last` itself is checked last.
    always_comb begin
        winner = last;
        idx    = '0;
        found  = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = last + NUM_SLCT_LNS'(i);
            if (!found && i_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Priority pointer follows every completed handshake; reset points at
    // N-1 so channel 0 is first in line after release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  last <= NUM_SLCT_LNS'(N - 1);
        else if (xfer) last <= winner;
    end
`endif

    // One-hot accept toward the winner; forced low while in reset so no
    // handshake can complete during an asynchronous reset.
    always_comb begin
        o_ready = '0;
        if (i_rst_n && load_ok && any_valid) o_ready[winner] = 1'b1;
    end

    // Output register: load on handshake, empty on drain without refill,
    // otherwise hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_out   <= '0;
            o_grant <= '0;
        end else if (xfer) begin
            o_valid <= 1'b1;
            o_out   <= i_input_signal[winner];
            o_grant <= winner;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed, table-driven bench for rr_arb_mux (NUM_SLCT_LNS=2, PCK_SZ=4).
module tb_rr_arb_mux;

    logic       i_clk;
    logic       i_rst_n;
    logic [3:0] i_valid;
    logic [3:0] i_input_signal [3:0];
    logic [3:0] o_ready;
    logic       o_valid;
    logic [3:0] o_out;
    logic [1:0] o_grant;
    logic       i_ready;

    int errors = 0;
    int checks = 0;

    rr_arb_mux #(.NUM_SLCT_LNS(2), .PCK_SZ(4)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_valid        (i_valid),
        .i_input_signal (i_input_signal),
        .o_ready        (o_ready),
        .o_valid        (o_valid),
        .o_out          (o_out),
        .o_grant        (o_grant),
        .i_ready        (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  v;    // i_valid
        logic        r;    // i_ready
        logic [15:0] d;    // {d3,d2,d1,d0}
        logic [3:0]  rdy;  // expected o_ready before the edge
        logic        ov;   // expected o_valid after the edge
        logic [3:0]  out;  // expected o_out after the edge
        logic [1:0]  g;    // expected o_grant after the edge
    } vec_t;

    vec_t vecs [16];
    int   nvec;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic r, input logic [15:0] d);
        i_valid = v;
        i_ready = r;
        for (int k = 0; k < 4; k++) i_input_signal[k] = d[k*4 +: 4];
    endtask

    task automatic add(input logic [3:0] v, input logic r, input logic [15:0] d,
                       input logic [3:0] rdy, input logic ov, input logic [3:0] out,
                       input logic [1:0] g);
        vecs[nvec] = '{v: v, r: r, d: d, rdy: rdy, ov: ov, out: out, g: g};
        nvec++;
    endtask

    initial begin
        nvec = 0;
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
        // streaming: channel 0 always wins
        add(4'b1111, 1'b1, 16'h4321, 4'b0001, 1'b1, 4'h1, 2'd0);
        add(4'b1111, 1'b1, 16'h4321, 4'b0001, 1'b1, 4'h1, 2'd0);
        add(4'b1111, 1'b1, 16'h4321, 4'b0001, 1'b1, 4'h1, 2'd0);
        add(4'b1111, 1'b1, 16'h4321, 4'b0001, 1'b1, 4'h1, 2'd0);
        add(4'b1111, 1'b1, 16'h4321, 4'b0001, 1'b1, 4'h1, 2'd0);
`else
        // streaming round-robin from reset: 0,1,2,3,0
        add(4'b1111, 1'b1, 16'h4321, 4'b0001, 1'b1, 4'h1, 2'd0);
        add(4'b1111, 1'b1, 16'h4321, 4'b0010, 1'b1, 4'h2, 2'd1);
        add(4'b1111, 1'b1, 16'h4321, 4'b0100, 1'b1, 4'h3, 2'd2);
        add(4'b1111, 1'b1, 16'h4321, 4'b1000, 1'b1, 4'h4, 2'd3);
        add(4'b1111, 1'b1, 16'h4321, 4'b0001, 1'b1, 4'h1, 2'd0);
`endif
        // single channel 2 carrying 4'hA
        add(4'b0100, 1'b1, 16'hBA98, 4'b0100, 1'b1, 4'hA, 2'd2);
        // load channel 1 with 4'h5, then backpressure for 3 cycles
        add(4'b0010, 1'b1, 16'h7659, 4'b0010, 1'b1, 4'h5, 2'd1);
        add(4'b1111, 1'b0, 16'h7659, 4'b0000, 1'b1, 4'h5, 2'd1);
        add(4'b1111, 1'b0, 16'h7659, 4'b0000, 1'b1, 4'h5, 2'd1);
        add(4'b1111, 1'b0, 16'h7659, 4'b0000, 1'b1, 4'h5, 2'd1);
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
        add(4'b1111, 1'b1, 16'h7659, 4'b0001, 1'b1, 4'h9, 2'd0);
`else
        // release: next after channel 1 is channel 2
        add(4'b1111, 1'b1, 16'h7659, 4'b0100, 1'b1, 4'h6, 2'd2);
`endif
        // drain without refill: o_valid drops, data/grant held
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
        add(4'b0000, 1'b1, 16'h7659, 4'b0000, 1'b0, 4'h9, 2'd0);
`else
        add(4'b0000, 1'b1, 16'h7659, 4'b0000, 1'b0, 4'h6, 2'd2);
`endif
        // empty register accepts even with i_ready low
        add(4'b1000, 1'b0, 16'h7659, 4'b1000, 1'b1, 4'h7, 2'd3);
        // drain and reload same cycle; pointer wraps 3 -> 0
        add(4'b0011, 1'b1, 16'h7659, 4'b0001, 1'b1, 4'h9, 2'd0);
    end

    initial begin
        // reset with random inputs, checked before any clock edge
        i_rst_n = 1'b0;
        drive(4'($urandom), 1'($urandom), 16'($urandom));
        #3;
        check("rst_valid", o_valid, 0);
        check("rst_out",   o_out,   0);
        check("rst_grant", o_grant, 0);
        check("rst_ready", o_ready, 0);
        @(posedge i_clk);
        #1 drive(4'($urandom), 1'b1, 16'($urandom));
        #1 check("rst_ready_clk", o_ready, 0);
        check("rst_valid_clk", o_valid, 0);

        @(posedge i_clk);
        #1 drive(4'b0000, 1'b0, 16'h0000);
        i_rst_n = 1'b1;

        for (int i = 0; i < nvec; i++) begin
            drive(vecs[i].v, vecs[i].r, vecs[i].d);
            #1 check($sformatf("v%0d_ready", i), o_ready, vecs[i].rdy);
            @(posedge i_clk);
            #1;
            check($sformatf("v%0d_valid", i), o_valid, vecs[i].ov);
            check($sformatf("v%0d_out",   i), o_out,   vecs[i].out);
            check($sformatf("v%0d_grant", i), o_grant, vecs[i].g);
        end

        // asynchronous reset between edges while streaming
        drive(4'b1111, 1'b1, 16'h4321);
        @(posedge i_clk);
        #1 check("mid_valid_pre", o_valid, 1);
        #2 i_rst_n = 1'b0;
        #1;
        check("mid_valid_async", o_valid, 0);
        check("mid_out_async",   o_out,   0);
        check("mid_ready_async", o_ready, 0);
        @(posedge i_clk);
        #1 check("mid_valid_hold", o_valid, 0);
        #2 i_rst_n = 1'b1;
        #1 check("post_rst_ready", o_ready, 4'b0001);
        @(posedge i_clk);
        #1;
        check("post_rst_valid", o_valid, 1);
        check("post_rst_grant", o_grant, 0);
        check("post_rst_out",   o_out,   1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
